qreg_tx: RTL and testbench

QREG_TX -- requirements
Module: qreg_tx

---
 rtl/qreg_tx_pkg.sv | 16 +
 rtl/qreg_tx_out_fifo.sv | 64 ++++++
 rtl/qreg_tx.sv | 111 +++++++++++
 tb/tb_qreg_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/qreg_tx_pkg.sv
// Shared constants and FSM encoding for the qreg serial transmitter.
package qreg_tx_pkg;

    localparam int unsigned BYTE_W           = 8;
    localparam int unsigned CLKS_PER_BIT_DEF = 4;
    localparam int unsigned CYC_CNT_W        = 8;
    localparam int unsigned BIT_IDX_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/qreg_tx_out_fifo.sv
// Byte FIFO between the qreg load port and the transmitter, with registered full/empty.
module out_fifo
    import qreg_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  count;
    logic [OCC_W-1:0]  count_nx;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nx = count + OCC_W'(push_ok) - OCC_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nx;
            full  <= (count_nx == OCC_W'(DEPTH));
            empty <= (count_nx == '0);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/qreg_tx.sv
// qreg output path: load FIFO feeding an 8N1 LSB-first serial transmitter.
module qreg_tx
    import qreg_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned DEPTH        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [BYTE_W-1:0] data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              busy,
    output logic              txd
);

    tx_state_t              state;
    logic [BYTE_W-1:0]      shift;
    logic [BYTE_W-1:0]      head;
    logic [CYC_CNT_W-1:0]   clk_cnt;
    logic [BIT_IDX_W-1:0]   bit_cnt;
    logic                   pop;
    logic                   bit_done;

    assign pop      = (state == ST_IDLE) && !empty;
    assign bit_done = (clk_cnt == CYC_CNT_W'(CLKS_PER_BIT - 1));

    out_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (load),
        .pop   (pop),
        .din   (data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Transmit FSM; txd is loaded one edge ahead so it changes together with state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shift    <= '0;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (load && full && !pop) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (!empty) begin
                        shift   <= head;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        txd     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        txd     <= shift[0];
                        state   <= ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CYC_CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_IDX_W'(BYTE_W - 1)) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_IDX_W'(1);
                            shift   <= {1'b0, shift[BYTE_W-1:1]};
                            txd     <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CYC_CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CYC_CNT_W'(1);
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qreg_tx.sv
// Bench for qreg_tx: expected bytes queued at load time, serial monitor decodes txd and compares.
module tb_qreg_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       load, load2;
    logic [7:0] data, data2;
    logic       full, empty, overflow, busy, txd;
    logic       full2, empty2, overflow2, busy2, txd2;

    int n_pass = 0;
    int n_checks = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    qreg_tx #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .load(load), .data(data),
        .full(full), .empty(empty), .overflow(overflow), .busy(busy), .txd(txd)
    );

    qreg_tx #(.CLKS_PER_BIT(2), .DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .load(load2), .data(data2),
        .full(full2), .empty(empty2), .overflow(overflow2), .busy(busy2), .txd(txd2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: decode frames from txd, check shape/busy/gap, compare against the queue.
    int         k, gap, bi;
    logic       in_frame = 1'b0, post = 1'b0, pending = 1'b0, shape_ok;
    logic [7:0] rx, exp_b;

    always @(negedge clk) begin
        if (!reset) begin
            in_frame = 1'b0; post = 1'b0; pending = 1'b0; gap = 0;
        end else begin
            if (!in_frame) begin
                if (post) begin
                    chk("idle_after_frame_busy", int'(busy), 0);
                    post = 1'b0;
                end
                if (txd == 1'b0) begin
                    if (pending) chk("frame_gap", gap, 1);
                    pending = 1'b0; in_frame = 1'b1; k = 0; shape_ok = 1'b1; rx = '0;
                end else begin
                    gap++;
                end
            end
            if (in_frame) begin
                if (busy !== 1'b1) shape_ok = 1'b0;
                if (k < CPB) begin
                    if (txd !== 1'b0) shape_ok = 1'b0;
                end else if (k < 9 * CPB) begin
                    bi = k / CPB - 1;
                    if (k % CPB == 0) rx[3'(bi)] = txd;
                    else if (txd !== rx[3'(bi)]) shape_ok = 1'b0;
                end else if (txd !== 1'b1) begin
                    shape_ok = 1'b0;
                end
                k++;
                if (k == 10 * CPB) begin
                    in_frame = 1'b0; post = 1'b1; gap = 0;
                    if (q.size() == 0) begin
                        chk("frame_unexpected", q.size(), 1);
                    end else begin
                        exp_b = q.pop_front();
                        chk("frame_byte", int'(rx), int'(exp_b));
                        chk("frame_shape", int'(shape_ok), 1);
                    end
                    pending = (q.size() != 0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit sent);
        load = 1'b1; data = b;
        if (sent) q.push_back(b);
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        do begin
            @(negedge clk); n++;
        end while ((q.size() != 0 || busy) && n < budget);
        chk("drain_queue", q.size(), 0);
        chk("drain_busy", int'(busy), 0);
        @(posedge clk); #1;
    endtask

    int n, bad, bcnt, lcnt;

    initial begin
        reset = 1'b0; load = 1'b0; data = '0; load2 = 1'b0; data2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_txd", int'(txd), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_overflow", int'(overflow), 0);
        @(posedge clk); #1 reset = 1'b1;

        // Single byte: idle one cycle after the load edge, START the cycle after.
        @(posedge clk); #1;
        send(8'hA5, 1'b1);
        @(negedge clk);
        chk("a5_lat_txd_idle", int'(txd), 1);
        chk("a5_lat_busy_idle", int'(busy), 0);
        chk("a5_lat_empty", int'(empty), 0);
        @(negedge clk);
        chk("a5_start_txd", int'(txd), 0);
        chk("a5_start_busy", int'(busy), 1);
        drain(200);

        // Three back-to-back bytes.
        send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1);
        repeat (60) @(negedge clk);
        chk("b2b_empty_before_third", int'(empty), 0);
        repeat (30) @(negedge clk);
        chk("b2b_empty_after_third", int'(empty), 1);
        chk("b2b_busy_third", int'(busy), 1);
        drain(300);

        // Overflow: sixth load lands on a full FIFO with no pop.
        reset_dut();
        chk("ovf_clear", int'(overflow), 0);
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b1);
        send(8'h15, 1'b0);
        @(negedge clk);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_full", int'(full), 1);
        drain(400);
        chk("ovf_sticky", int'(overflow), 1);

        // Load while full on the same edge as a pop.
        reset_dut();
        for (int i = 0; i < 5; i++) send(8'(8'h20 + i), 1'b1);
        @(negedge clk);
        chk("fp_full", int'(full), 1);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk); n++;
        end
        chk("fp_idle_found", int'(busy), 0);
        chk("fp_full_before_pop", int'(full), 1);
        load = 1'b1; data = 8'h77; q.push_back(8'h77);
        @(posedge clk); #1 load = 1'b0;
        @(negedge clk);
        chk("fp_full_after", int'(full), 1);
        chk("fp_no_overflow", int'(overflow), 0);
        drain(400);
        chk("fp_empty_end", int'(empty), 1);

        // Reset in the fifth data bit of 0x3C with 0x55 still queued.
        reset_dut();
        send(8'h3C, 1'b1);
        send(8'h55, 1'b1);
        repeat (21) @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_txd", int'(txd), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_empty", int'(empty), 1);
        chk("mid_rst_overflow", int'(overflow), 0);
        @(posedge clk); #1 reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("mid_rst_quiet", bad, 0);

        // CLKS_PER_BIT=2 instance, byte 0xFF.
        @(posedge clk); #1 load2 = 1'b1; data2 = 8'hFF;
        @(posedge clk); #1 load2 = 1'b0;
        bcnt = 0; lcnt = 0; bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (txd2 === 1'b0) begin
                lcnt++;
                if (!busy2 || bcnt >= 2) bad++;
            end
            if (busy2) bcnt++;
        end
        chk("ff_busy_cycles", bcnt, 20);
        chk("ff_low_cycles", lcnt, 2);
        chk("ff_low_outside_start", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
